// File: rtl/mux16_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux16_rr_scheduler
//
// Round-robin scheduler sharing one 16:1 single-bit mux among sixteen
// requesters. It drives the mux select and a one-hot grant. While a grant is
// active it registers the returning mux output as a sample stream.
//
// Each grant is followed by one GAP cycle and then one IDLE cycle. This
// guarantees two grant-free cycles between back-to-back owners.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous, active-high reset
//   en            in   1   arbitration enable, sampled only in IDLE
//   req           in  16   request per channel (bit i -> mux input i)
//   release_grant in   1   current owner ends its grant ("release" is a
//                          reserved word, hence the longer name)
//   mux_in        in   1   combinational 16:1 mux output for current sel
//   sel           out  4   registered mux select (binary channel index)
//   grant         out 16   registered one-hot grant, zero outside GRANT
//   busy          out  1   high while in GRANT
//   data_q        out  1   registered mux_in sample
//   data_valid    out  1   high the cycle after each GRANT cycle
// ---------------------------------------------------------------------------
module mux16_rr_scheduler #(
    parameter int unsigned HOLD_MAX = 8  // max consecutive grant cycles, 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        release_grant,
    input  logic        mux_in,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        busy,
    output logic        data_q,
    output logic        data_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  ptr_r;
    logic [3:0]  sel_r;
    logic [15:0] grant_r;
    logic        busy_r;
    logic [7:0]  hold_cnt_r;
    logic        data_q_r;
    logic        data_valid_r;

    logic [4:0]  win_s;        // {found, index}
    logic        start_s;
    logic        timeout_s;
    logic        exit_s;

    // Scan ptr, ptr+1, ... (mod 16) and return {found, first requesting index}.
    // The 4-bit candidate wraps naturally, so 15 is followed by 0.
    function automatic logic [4:0] find_winner(input logic [15:0] r,
                                               input logic [3:0]  p);
        logic       found;
        logic [3:0] idx;
        logic [3:0] cand;
        found = 1'b0;
        idx   = p;
        for (int k = 0; k < 16; k++) begin
            cand = p + 4'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Arbitration result and grant-termination conditions.
    always_comb begin
        win_s     = find_winner(req, ptr_r);
        start_s   = en && win_s[4];
        timeout_s = (hold_cnt_r == 8'(HOLD_MAX - 1));
        // A single exit covers release, dropped request and timeout together.
        exit_s    = release_grant || !req[sel_r] || timeout_s;
    end

    // Next-state logic for IDLE -> GRANT -> GAP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (exit_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pointer, grant, hold counter and sampled-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= 4'd0;
            sel_r        <= 4'd0;
            grant_r      <= 16'd0;
            busy_r       <= 1'b0;
            hold_cnt_r   <= 8'd0;
            data_q_r     <= 1'b0;
            data_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            data_valid_r <= (state_r == ST_GRANT);
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        sel_r      <= win_s[3:0];
                        grant_r    <= 16'd1 << win_s[3:0];
                        busy_r     <= 1'b1;
                        hold_cnt_r <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    hold_cnt_r <= hold_cnt_r + 8'd1;
                    data_q_r   <= mux_in;
                    if (exit_s) begin
                        grant_r <= 16'd0;
                        busy_r  <= 1'b0;
                        ptr_r   <= sel_r + 4'd1;
                    end
                end
                ST_GAP: begin
                    grant_r <= 16'd0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: drop any grant and recover via IDLE.
                    grant_r <= 16'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = sel_r;
    assign grant      = grant_r;
    assign busy       = busy_r;
    assign data_q     = data_q_r;
    assign data_valid = data_valid_r;

endmodule
